// File: rtl/params_pkg.sv
// Shared constants and types for the data-memory access controller.
//   DMEM_LOAD_SIZE_*   : load type encodings (signed/unsigned byte/half, word)
//   DMEM_STORE_SIZE_*  : store size encodings
//   TRAP_CODE_*        : access-fault trap codes reported on completion
//   dmem_ctrl_state_t  : sequencing FSM states
//   load_size()        : maps a load type onto a store-size style size code
//   size_mask()        : byte-lane mask for a size code at offset 0
//   needs_split()      : whether an access of a size at a byte offset crosses a word
package params_pkg;

    localparam logic [2:0] DMEM_LOAD_SIZE_BYTE  = 3'b000;
    localparam logic [2:0] DMEM_LOAD_SIZE_HALF  = 3'b001;
    localparam logic [2:0] DMEM_LOAD_SIZE_WORD  = 3'b010;
    localparam logic [2:0] DMEM_LOAD_SIZE_BYTEU = 3'b100;
    localparam logic [2:0] DMEM_LOAD_SIZE_HALFU = 3'b101;

    localparam logic [1:0] DMEM_STORE_SIZE_BYTE = 2'b00;
    localparam logic [1:0] DMEM_STORE_SIZE_HALF = 2'b01;
    localparam logic [1:0] DMEM_STORE_SIZE_WORD = 2'b10;

    localparam logic [30:0] TRAP_CODE_LOAD_ACCESS_FAULT  = 31'd5;
    localparam logic [30:0] TRAP_CODE_STORE_ACCESS_FAULT = 31'd7;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1,
        DONE
    } dmem_ctrl_state_t;

    // Unknown load types are treated as full words.
    function automatic logic [1:0] load_size(input logic [2:0] lt);
        case (lt)
            DMEM_LOAD_SIZE_BYTE, DMEM_LOAD_SIZE_BYTEU: return DMEM_STORE_SIZE_BYTE;
            DMEM_LOAD_SIZE_HALF, DMEM_LOAD_SIZE_HALFU: return DMEM_STORE_SIZE_HALF;
            default:                                   return DMEM_STORE_SIZE_WORD;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            DMEM_STORE_SIZE_BYTE: return 4'b0001;
            DMEM_STORE_SIZE_HALF: return 4'b0011;
            default:              return 4'b1111;
        endcase
    endfunction

    function automatic logic needs_split(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            DMEM_STORE_SIZE_BYTE: return 1'b0;
            DMEM_STORE_SIZE_HALF: return off == 2'd3;
            default:              return off != 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_unit.sv
// Load data formatter: selects the addressed bytes of a read word and
// sign/zero extends them according to the load type.
//   load_type_i : DMEM_LOAD_SIZE_*
//   addr_lsb2_i : byte offset inside the word
//   rdata_i     : raw read word
//   data_o      : extended load result
//   rmask_o     : byte lanes read
//   misalign_o  : access not naturally aligned at addr_lsb2_i
module load_unit
    import params_pkg::*;
(
    input  logic [2:0]  load_type_i,
    input  logic [1:0]  addr_lsb2_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o,
    output logic [3:0]  rmask_o,
    output logic        misalign_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_lsb2_i, 3'b000};

    always_comb begin
        data_o     = shifted;
        rmask_o    = 4'b1111;
        misalign_o = 1'b0;
        case (load_type_i)
            DMEM_LOAD_SIZE_BYTE: begin
                data_o  = {{24{shifted[7]}}, shifted[7:0]};
                rmask_o = 4'b0001 << addr_lsb2_i;
            end
            DMEM_LOAD_SIZE_BYTEU: begin
                data_o  = {24'b0, shifted[7:0]};
                rmask_o = 4'b0001 << addr_lsb2_i;
            end
            DMEM_LOAD_SIZE_HALF: begin
                data_o     = {{16{shifted[15]}}, shifted[15:0]};
                rmask_o    = 4'b0011 << addr_lsb2_i;
                misalign_o = addr_lsb2_i[0];
            end
            DMEM_LOAD_SIZE_HALFU: begin
                data_o     = {16'b0, shifted[15:0]};
                rmask_o    = 4'b0011 << addr_lsb2_i;
                misalign_o = addr_lsb2_i[0];
            end
            default: begin
                misalign_o = addr_lsb2_i != 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: sequences one MEM-stage load/store onto a
// req/gnt/rvalid bus, splitting word-crossing accesses into two aligned beats
// and merging the load beats before formatting.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_*                  : MEM-stage op (valid, we, load type, store size, addr, wdata)
//   flush_i                : kill the in-flight op
//   busy_o                 : op in flight, MEM stage stalls
//   rsp_*                  : one-cycle completion (data, trap, trap code)
//   dmem_req_o/gnt_i       : beat request handshake
//   dmem_addr/we/be/wdata_o: beat payload, held stable until gnt
//   dmem_rvalid/rdata/err_i: beat response
module dmem_access_ctrl
    import params_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            req_valid_i,
    input  logic            req_we_i,
    input  logic [2:0]      req_load_type_i,
    input  logic [1:0]      req_store_size_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_trap_o,
    output logic [XLEN-2:0] rsp_trap_code_o,
    output logic            dmem_req_o,
    input  logic            dmem_gnt_i,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_err_i
);

    dmem_ctrl_state_t state_q, state_d;

    logic            we_q, split_q, flush_q, trap_q;
    logic [2:0]      lt_q;
    logic [1:0]      ss_q;
    logic [XLEN-1:0] addr_q, wdata_q, rd0_q, rd1_q, rdata_q;
    logic [XLEN-2:0] code_q;

    logic accept, cap0, cap1, set_flush, to_done, trap_d;

    // Access geometry from the latched op.
    logic [1:0]        off, sz_q, sz_in;
    logic [7:0]        m8;
    logic [2*XLEN-1:0] w64;
    logic [XLEN-1:0]   beat0_addr, beat1_addr;

    assign off        = addr_q[1:0];
    assign sz_q       = we_q ? ss_q : load_size(lt_q);
    assign sz_in      = req_we_i ? req_store_size_i : load_size(req_load_type_i);
    assign m8         = {4'b0, size_mask(sz_q)} << off;
    assign w64        = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    assign beat0_addr = {addr_q[XLEN-1:2], 2'b00};
    assign beat1_addr = beat0_addr + 32'd4;   // wraps at the top of memory

    // Load merge uses the beat arriving this cycle so the formatted result can
    // be registered on the same edge that enters DONE.
    logic [2*XLEN-1:0] rd_pair;
    logic [XLEN-1:0]   merged, lu_data;
    logic [3:0]        lu_rmask;
    logic              lu_misalign;

    always_comb begin
        rd_pair = {rd1_q, rd0_q};
        if (state_q == RSP0)      rd_pair = {{XLEN{1'b0}}, dmem_rdata_i};
        else if (state_q == RSP1) rd_pair = {dmem_rdata_i, rd0_q};
    end

    assign merged = rd_pair[{1'b0, off, 3'b000} +: XLEN];

    load_unit u_load_unit (
        .load_type_i (lt_q),
        .addr_lsb2_i (2'b00),
        .rdata_i     (merged),
        .data_o      (lu_data),
        .rmask_o     (lu_rmask),
        .misalign_o  (lu_misalign)
    );

    // Lanes above the largest shift, the read mask and the misalign flag have
    // no consumer once beats are merged to offset 0.
    logic unused_bits;
    assign unused_bits = ^{rd_pair[63:56], lu_rmask, lu_misalign};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_o   = 1'b0;
        dmem_addr_o  = '0;
        dmem_we_o    = 1'b0;
        dmem_be_o    = 4'b0;
        dmem_wdata_o = '0;
        accept       = 1'b0;
        cap0         = 1'b0;
        cap1         = 1'b0;
        set_flush    = 1'b0;
        to_done      = 1'b0;
        trap_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = REQ0;
                end
            end
            REQ0, REQ1: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = (state_q == REQ0) ? beat0_addr : beat1_addr;
                dmem_be_o    = (state_q == REQ0) ? m8[3:0] : m8[7:4];
                dmem_wdata_o = !we_q ? '0 :
                               (state_q == REQ0) ? w64[XLEN-1:0] : w64[2*XLEN-1:XLEN];
                // Once granted the beat must drain, so a flush is only noted.
                if (dmem_gnt_i) begin
                    state_d   = (state_q == REQ0) ? RSP0 : RSP1;
                    set_flush = flush_i;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            RSP0, RSP1: begin
                if (dmem_rvalid_i) begin
                    cap0 = (state_q == RSP0);
                    cap1 = (state_q == RSP1);
                    if (flush_q || flush_i) begin
                        state_d = IDLE;
                    end else if (dmem_err_i || !split_q || state_q == RSP1) begin
                        state_d = DONE;
                        to_done = 1'b1;
                        trap_d  = dmem_err_i;
                    end else begin
                        state_d = REQ1;
                    end
                end else begin
                    set_flush = flush_i;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            lt_q    <= 3'b0;
            ss_q    <= 2'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            flush_q <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rdata_q <= '0;
            trap_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                lt_q    <= req_load_type_i;
                ss_q    <= req_store_size_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                split_q <= needs_split(sz_in, req_addr_i[1:0]);
                flush_q <= 1'b0;
                rd0_q   <= '0;
                rd1_q   <= '0;
            end else if (set_flush) begin
                flush_q <= 1'b1;
            end
            if (cap0) rd0_q <= dmem_rdata_i;
            if (cap1) rd1_q <= dmem_rdata_i;
            if (to_done) begin
                rdata_q <= (we_q || trap_d) ? '0 : lu_data;
                trap_q  <= trap_d;
                code_q  <= !trap_d ? '0 :
                           we_q ? TRAP_CODE_STORE_ACCESS_FAULT : TRAP_CODE_LOAD_ACCESS_FAULT;
            end
        end
    end

    assign busy_o          = state_q != IDLE;
    assign rsp_valid_o     = state_q == DONE;
    assign rsp_rdata_o     = rsp_valid_o ? rdata_q : '0;
    assign rsp_trap_o      = rsp_valid_o & trap_q;
    assign rsp_trap_code_o = rsp_valid_o ? code_q : '0;

endmodule
